// File: rtl/ram1m_pkg.sv
// ram1m_pkg: shared types and constants for the 1MB CPC RAM expansion cycle controller.
// Revision: 1.0
`default_nettype none

package ram1m_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_HOLD = 2'd3
  } cyc_state_t;

  localparam logic [1:0] SIZE_OFF  = 2'b00;
  localparam logic [1:0] SIZE_64K  = 2'b01;
  localparam logic [1:0] SIZE_512K = 2'b10;
  localparam logic [1:0] SIZE_1M   = 2'b11;

  localparam logic [3:0] DEFAULT_SHADOW_BANK = 4'b0111;
  localparam logic [1:0] CFG_PORT_ID         = 2'b11;

  // Translate a config-port write into the ramblock register value for the given RAM size.
  function automatic logic [6:0] decode_ramblock(input logic [1:0] size, input logic adr8,
                                                 input logic [5:0] d, input logic [3:0] shadow);
    logic [6:0] blk;
    case (size)
      SIZE_64K:  blk = {4'b1000, d[2:0]};
      SIZE_512K: blk = {1'b1, d};
      default: begin
        blk = {adr8, d};
        if ({adr8, d[5:3]} == shadow) blk[3] = 1'b0;
      end
    endcase
    return blk;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram1m_map.sv
// ram1m_map: combinational quadrant-to-expansion-page decode from ramblock and A15/A14.
// Revision: 1.0
`default_nettype none

module ram1m_map
  import ram1m_pkg::*;
(
  input  logic [6:0] ramblock,
  input  logic       adr15,
  input  logic       adr14,
  output logic       exp,
  output logic       cs1_sel,
  output logic [4:0] ramadrhi
);

  logic [1:0] quad;
  logic [1:0] page;

  always_comb begin
    quad = {adr15, adr14};
    exp  = 1'b0;
    page = 2'b00;
    case (ramblock[2:0])
      3'd1, 3'd3: begin
        if (quad == 2'd3) begin
          exp  = 1'b1;
          page = 2'd3;
        end
      end
      3'd2: begin
        exp  = 1'b1;
        page = quad;
      end
      // Modes 4..7 map a single page into the 0x4000 window.
      3'd4, 3'd5, 3'd6, 3'd7: begin
        if (quad == 2'd1) begin
          exp  = 1'b1;
          page = ramblock[1:0];
        end
      end
      default: ;
    endcase
    cs1_sel  = ramblock[6];
    ramadrhi = {ramblock[5:3], page};
  end

endmodule

`default_nettype wire

// File: rtl/ram1m_cycle_ctrl.sv
// ram1m_cycle_ctrl: Z80 memory-cycle sequencer and 0x7Fxx bank-config capture for the 1MB CPC RAM card.
// Optional macro CFG_DEFER_EN defers ramblock updates to an idle bus. Revision: 1.0
`default_nettype none

module ram1m_cycle_ctrl
  import ram1m_pkg::*;
#(
  parameter logic [3:0] SHADOW_BANK = DEFAULT_SHADOW_BANK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mreq_b,
  input  logic       iorq_b,
  input  logic       rd_b,
  input  logic       wr_b,
  input  logic       rfsh_b,
  input  logic       adr15,
  input  logic       adr14,
  input  logic       adr8,
  input  logic [7:0] data,
  input  logic [3:0] dip,
  output logic       ramcs0_b,
  output logic       ramcs1_b,
  output logic       ramoe_b,
  output logic       ramwe_b,
  output logic [4:0] ramadrhi,
  output logic       ramdis
);

  cyc_state_t state, state_nx;

  logic       io_seen;
  logic [6:0] ramblock;
  logic       card_on;
  logic       cfg_hit;
  logic [6:0] cfg_value;
  logic       unused_dip;

  logic       map_exp, map_cs1;
  logic [4:0] map_adrhi;
  logic       cyc_exp, cyc_cs1;
  logic [4:0] cyc_adrhi;
  logic       exp_nx, cs1_nx;
  logic [4:0] adrhi_nx;

  logic       cs0_b_nx, cs1_b_nx, oe_b_nx, we_b_nx, ramdis_nx;
  logic [4:0] ramadrhi_nx;

  assign unused_dip = ^dip[1:0];
  assign card_on    = (dip[3:2] != SIZE_OFF);
  assign cfg_hit    = !iorq_b && !wr_b && !adr15 && (data[7:6] == CFG_PORT_ID)
                      && !io_seen && card_on;
  assign cfg_value  = decode_ramblock(dip[3:2], adr8, data[5:0], SHADOW_BANK);

  always_ff @(posedge clk) begin
    if (reset)        io_seen <= 1'b0;
    else if (iorq_b)  io_seen <= 1'b0;
    else if (cfg_hit) io_seen <= 1'b1;
  end

`ifdef CFG_DEFER_EN
  logic [6:0] pending;
  logic       pending_vld;
  logic       bus_idle;

  assign bus_idle = (state == ST_IDLE) && mreq_b;

  // Last capture wins; it is applied only while the bus is quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= 7'd0;
      pending_vld <= 1'b0;
      ramblock    <= 7'd0;
    end else begin
      if (bus_idle && pending_vld) ramblock <= pending;
      if (cfg_hit) begin
        pending     <= cfg_value;
        pending_vld <= 1'b1;
      end else if (bus_idle) begin
        pending_vld <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset)        ramblock <= 7'd0;
    else if (cfg_hit) ramblock <= cfg_value;
  end
`endif

  ram1m_map u_map (
    .ramblock (ramblock),
    .adr15    (adr15),
    .adr14    (adr14),
    .exp      (map_exp),
    .cs1_sel  (map_cs1),
    .ramadrhi (map_adrhi)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    exp_nx      = cyc_exp;
    cs1_nx      = cyc_cs1;
    adrhi_nx    = cyc_adrhi;
    cs0_b_nx    = 1'b1;
    cs1_b_nx    = 1'b1;
    oe_b_nx     = 1'b1;
    we_b_nx     = 1'b1;
    ramdis_nx   = 1'b0;
    ramadrhi_nx = 5'd0;
    case (state)
      ST_IDLE: begin
        if (!mreq_b && rfsh_b) begin
          state_nx = ST_T1;
          exp_nx   = map_exp;
          cs1_nx   = map_cs1;
          adrhi_nx = map_adrhi;
        end
      end
      ST_T1:   state_nx = ST_T2;
      ST_T2:   state_nx = ST_HOLD;
      ST_HOLD: if (mreq_b) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    // Outputs are driven from the frozen mapping; leaving to IDLE forces reset values.
    if ((state_nx != ST_IDLE) && exp_nx && card_on) begin
      cs0_b_nx    = cs1_nx;
      cs1_b_nx    = !cs1_nx;
      ramdis_nx   = 1'b1;
      ramadrhi_nx = adrhi_nx;
      oe_b_nx     = rd_b;
      we_b_nx     = wr_b || (state_nx == ST_T1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_exp   <= 1'b0;
      cyc_cs1   <= 1'b0;
      cyc_adrhi <= 5'd0;
      ramcs0_b  <= 1'b1;
      ramcs1_b  <= 1'b1;
      ramoe_b   <= 1'b1;
      ramwe_b   <= 1'b1;
      ramdis    <= 1'b0;
      ramadrhi  <= 5'd0;
    end else begin
      cyc_exp   <= exp_nx;
      cyc_cs1   <= cs1_nx;
      cyc_adrhi <= adrhi_nx;
      ramcs0_b  <= cs0_b_nx;
      ramcs1_b  <= cs1_b_nx;
      ramoe_b   <= oe_b_nx;
      ramwe_b   <= we_b_nx;
      ramdis    <= ramdis_nx;
      ramadrhi  <= ramadrhi_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram1m_cycle_ctrl.sv
// tb_ram1m_cycle_ctrl: directed and randomized bus-cycle stimulus checked against a behavioural model.
// Revision: 1.0
`default_nettype none

module tb_ram1m_cycle_ctrl;

  localparam logic [9:0] RST_OUT = 10'b1111_0_00000;

  logic       clk = 1'b0;
  logic       reset;
  logic       mreq_b, iorq_b, rd_b, wr_b, rfsh_b;
  logic       adr15, adr14, adr8;
  logic [7:0] data;
  logic [3:0] dip;
  logic       ramcs0_b, ramcs1_b, ramoe_b, ramwe_b, ramdis;
  logic [4:0] ramadrhi;
  logic [9:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_rb;
  bit m_seen;
  bit cyc_hit, cyc_hi;
  int cyc_adr;

  ram1m_cycle_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .mreq_b   (mreq_b),
    .iorq_b   (iorq_b),
    .rd_b     (rd_b),
    .wr_b     (wr_b),
    .rfsh_b   (rfsh_b),
    .adr15    (adr15),
    .adr14    (adr14),
    .adr8     (adr8),
    .data     (data),
    .dip      (dip),
    .ramcs0_b (ramcs0_b),
    .ramcs1_b (ramcs1_b),
    .ramoe_b  (ramoe_b),
    .ramwe_b  (ramwe_b),
    .ramadrhi (ramadrhi),
    .ramdis   (ramdis)
  );

  always #5 clk = ~clk;

  assign outs = {ramcs0_b, ramcs1_b, ramoe_b, ramwe_b, ramdis, ramadrhi};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic int new_ramblock(input int size, input int a8, input int d);
    int r;
    case (size)
      1: r = 64 + (d % 8);
      2: r = 64 + (d % 64);
      default: begin
        r = a8 * 64 + (d % 64);
        if (a8 * 8 + (d / 8) % 8 == 7) r = r - 8;
      end
    endcase
    return r;
  endfunction

  // Freeze the expected mapping for a cycle starting now at the given CPU address.
  task automatic latch_map(input int addr);
    int mode, quad, page;
    mode = m_rb % 8;
    quad = addr / 16384;
    cyc_hit = 1'b0;
    page = 0;
    if (mode == 2) begin
      cyc_hit = 1'b1; page = quad;
    end else if ((mode == 1 || mode == 3) && quad == 3) begin
      cyc_hit = 1'b1; page = 3;
    end else if (mode >= 4 && quad == 1) begin
      cyc_hit = 1'b1; page = mode - 4;
    end
    cyc_adr = ((m_rb / 8) % 8) * 4 + page;
    cyc_hi  = (m_rb >= 64);
  endtask

  function automatic logic [9:0] model_out(input int phase);
    logic [4:0] a;
    if (reset || phase == 0 || !cyc_hit || dip[3:2] == 2'b00) return RST_OUT;
    a = 5'(cyc_adr);
    return {cyc_hi, !cyc_hi, rd_b, (phase == 1) ? 1'b1 : wr_b, 1'b1, a};
  endfunction

  // One clock: predict outputs from what is being driven, update the config model, compare.
  task automatic tick(input string tag, input int phase);
    logic [9:0] want;
    want = model_out(phase);
    if (reset) begin
      m_rb = 0; m_seen = 1'b0; cyc_hit = 1'b0;
    end else if (iorq_b) begin
      m_seen = 1'b0;
    end else if (!wr_b && !adr15 && data[7:6] == 2'b11 && !m_seen && dip[3:2] != 2'b00) begin
      m_rb   = new_ramblock(int'(dip[3:2]), int'(adr8), int'(data));
      m_seen = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq(tag, {22'd0, outs}, {22'd0, want});
  endtask

  task automatic io_write(input logic a15, input logic a8, input logic [7:0] d, input logic [7:0] d2);
    adr15 = a15; adr8 = a8; data = d; iorq_b = 1'b0; wr_b = 1'b0;
    tick("io_wr", 0);
    data = d2;
    tick("io_wr_held", 0);
    iorq_b = 1'b1; wr_b = 1'b1; adr15 = 1'b0;
    tick("io_end", 0);
    tick("io_idle", 0);
  endtask

  task automatic mem_cycle(input logic [15:0] addr, input bit is_wr, input int holds,
                           input bit io_in_hold, input logic a8, input logic [7:0] d);
    adr15 = addr[15]; adr14 = addr[14];
    latch_map(int'(addr));
    mreq_b = 1'b0; rfsh_b = 1'b1; rd_b = is_wr; wr_b = !is_wr;
    tick("mem_t1", 1);
    tick("mem_t2", 2);
    tick("mem_hold", 3);
    for (int i = 0; i < holds; i++) tick("mem_hold_n", 3);
    if (io_in_hold) begin
      iorq_b = 1'b0; wr_b = 1'b0; adr15 = 1'b0; adr8 = a8; data = d;
      tick("mem_hold_io", 3);
      iorq_b = 1'b1;
    end
    mreq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1;
    tick("mem_end", 0);
    tick("mem_idle", 0);
  endtask

  task automatic refresh_cycle();
    mreq_b = 1'b0; rfsh_b = 1'b0;
    tick("rfsh", 0);
    tick("rfsh", 0);
    mreq_b = 1'b1; rfsh_b = 1'b1;
    tick("rfsh_end", 0);
  endtask

  initial begin
    int op;
    logic [7:0] d, d2;
    reset = 1'b1; mreq_b = 1'b1; iorq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; rfsh_b = 1'b1;
    adr15 = 1'b0; adr14 = 1'b0; adr8 = 1'b0; data = 8'h00; dip = 4'b1100;
    m_rb = 0; m_seen = 1'b0; cyc_hit = 1'b0; cyc_hi = 1'b0; cyc_adr = 0;
    tick("reset", 0);
    tick("reset", 0);
    reset = 1'b0;
    tick("idle", 0);
    tick("idle", 0);

    // Mode 0: internal RAM only
    mem_cycle(16'hC000, 1'b0, 0, 1'b0, 1'b0, 8'h00);

    // 1MB, OUT 0x7FFF,0xC4 then read 0x4000 -> CS1, bank 0 page 0
    dip = 4'b1100;
    io_write(1'b0, 1'b1, 8'hC4, 8'hC5);
    mem_cycle(16'h4000, 1'b0, 1, 1'b0, 1'b0, 8'h00);

    // 512K, OUT 0x7F00,0xC2 then write 0xC000 -> CS1, adrhi 00011, WE from T2
    dip = 4'b1000;
    io_write(1'b0, 1'b0, 8'hC2, 8'hC2);
    mem_cycle(16'hC000, 1'b1, 2, 1'b0, 1'b0, 8'h00);

    // 1MB shadow alias: adr8=0, data=0xFA -> ramblock 0110010, read 0x8000 -> CS0, 11010
    dip = 4'b1100;
    io_write(1'b0, 1'b0, 8'hFA, 8'hFA);
    mem_cycle(16'h8000, 1'b0, 0, 1'b0, 1'b0, 8'h00);

    // Config write in HOLD: current cycle keeps old mapping, next one uses new
    mem_cycle(16'h8000, 1'b0, 0, 1'b1, 1'b1, 8'hC4);
    mem_cycle(16'h4000, 1'b0, 0, 1'b0, 1'b0, 8'h00);

    // Reset in T2 of an expansion write
    dip = 4'b1000;
    io_write(1'b0, 1'b0, 8'hC2, 8'hC2);
    adr15 = 1'b1; adr14 = 1'b1;
    latch_map(16'hC000);
    mreq_b = 1'b0; rd_b = 1'b1; wr_b = 1'b0;
    tick("rst_t1", 1);
    tick("rst_t2", 2);
    reset = 1'b1; mreq_b = 1'b1; wr_b = 1'b1;
    tick("rst_mid", 0);
    reset = 1'b0;
    tick("rst_idle", 0);
    refresh_cycle();

    // Card disabled: captures ignored, no outputs
    dip = 4'b0000;
    io_write(1'b0, 1'b0, 8'hC2, 8'hC2);
    mem_cycle(16'hC000, 1'b1, 0, 1'b0, 1'b0, 8'h00);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        d  = 8'($urandom_range(0, 255));
        d2 = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) d[7:6] = 2'b11;
        io_write(($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), d, d2);
      end else if (op <= 7) begin
        mem_cycle(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), 1'b0, 1'b0, 8'h00);
      end else if (op == 8) begin
        refresh_cycle();
      end else begin
        dip = ($urandom_range(0, 5) == 0) ? 4'b0000 : {2'($urandom_range(1, 3)), 2'($urandom_range(0, 3))};
        tick("dip_idle", 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
